// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: pipelined Urdhva-Tiryagbhyam (Vedic) multiplier behind a
// valid/ready stream interface. The product is built from 2x2 base products
// that are merged four-at-a-time, one register level per merge.
//
// Parameters
//   WIDTH        operand width, power of two in 4..32 (product is 2*WIDTH)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     operand pair valid
//   in_ready     operands accepted this cycle (combinational, low on stall)
//   in_a, in_b   multiplicand / multiplier
//   in_signed    (VEDIC_SIGNED_EN only) treat operands as two's complement
//   out_valid    product valid
//   out_ready    downstream accepts product
//   out_product  a*b, 2*WIDTH bits, held stable while stalled
//   busy         any pipeline stage holds a valid token
//
// Optional feature: define VEDIC_SIGNED_EN to add the in_signed port.
// Latency is LEVELS+1 register stages: S0 operands, S1 base products,
// S2..S(LEVELS) merges; the last merge stage drives out_product.
module vedic_mult_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
`ifdef VEDIC_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned L      = LEVELS + 1;
    localparam int unsigned PW     = 2 * WIDTH;

    logic             advance;
    logic [L-1:0]     vld_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // 2x2 crosswise multiply: vertical, crosswise, vertical with ripple carry
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] p;
        logic       t;
        logic       u;
        logic       v;
        logic       c0;
        p    = '0;
        p[0] = x[0] & y[0];
        t    = x[1] & y[0];
        u    = x[0] & y[1];
        p[1] = t ^ u;
        c0   = t & u;
        v    = x[1] & y[1];
        p[2] = v ^ c0;
        p[3] = v & c0;
        return p;
    endfunction

    // The whole pipe freezes only when the output token is refused
    assign advance   = ~(vld_q[L-1] & ~out_ready);
    assign in_ready  = advance;
    assign out_valid = vld_q[L-1];
    assign busy      = |vld_q;

    // Stage valid bits; bubbles travel as zeros and are never collapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q <= {vld_q[L-2:0], in_valid};
        end
    end

`ifdef VEDIC_SIGNED_EN
    logic         sign_c;
    logic [L-2:0] sgn_q;

    // Signed operands enter as magnitudes; -2^(W-1) negates to 2^(W-1), which fits
    always_comb begin
        a_mag  = in_a;
        b_mag  = in_b;
        sign_c = 1'b0;
        if (in_signed) begin
            if (in_a[WIDTH-1]) begin
                a_mag = -in_a;
            end
            if (in_b[WIDTH-1]) begin
                b_mag = -in_b;
            end
            sign_c = in_a[WIDTH-1] ^ in_b[WIDTH-1];
        end
    end

    // Sign travels alongside the data up to the stage feeding the last merge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q <= '0;
        end else if (advance) begin
            sgn_q[0] <= sign_c;
            for (int unsigned i = 1; i < L - 1; i++) begin
                sgn_q[i] <= sgn_q[i-1];
            end
        end
    end
`else
    assign a_mag = in_a;
    assign b_mag = in_b;
`endif

    // S0: operand registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (advance) begin
            a_q <= a_mag;
            b_q <= b_mag;
        end
    end

    // Level k holds N*N products of C-bit operand chunks, index a_chunk*N + b_chunk
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned C  = 1 << k;
        localparam int unsigned N  = WIDTH / C;
        localparam int unsigned NN = N * N;
        localparam int unsigned QW = 2 * C;

        logic [QW-1:0] prod_d [NN];
        logic [QW-1:0] prod_q [NN];

        if (k == 1) begin : g_base
            // S1: every 2-bit chunk of a against every 2-bit chunk of b
            always_comb begin
                prod_d = '{default: '0};
                for (int unsigned i = 0; i < N; i++) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        prod_d[i*N + j] = vedic2x2(a_q[2*i +: 2], b_q[2*j +: 2]);
                    end
                end
            end
        end else begin : g_merge
            localparam int unsigned NP = 2 * N;

            // P = HH<<C + (HL+LH)<<(C/2) + LL, middle sum kept at full width
            always_comb begin
                prod_d = '{default: '0};
                for (int unsigned i = 0; i < N; i++) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        prod_d[i*N + j] =
                            (QW'(g_lvl[k-1].prod_q[(2*i+1)*NP + 2*j+1]) << C)
                          + ((QW'(g_lvl[k-1].prod_q[(2*i+1)*NP + 2*j])
                            + QW'(g_lvl[k-1].prod_q[(2*i)*NP + 2*j+1])) << (C/2))
                          + QW'(g_lvl[k-1].prod_q[(2*i)*NP + 2*j]);
                    end
                end
`ifdef VEDIC_SIGNED_EN
                // Final merge restores the sign of a signed product
                if (k == LEVELS && sgn_q[L-2]) begin
                    prod_d[0] = -prod_d[0];
                end
`endif
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prod_q <= '{default: '0};
            end else if (advance) begin
                prod_q <= prod_d;
            end
        end
    end

    assign out_product = PW'(g_lvl[LEVELS].prod_q[0]);

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. It generalises the combinational 4-bit Vedic multiplier to any power-of-two WIDTH. The product is built by recursive 2x2-base decomposition, with one register level per recursion level. It sits in the arithmetic datapath behind a valid/ready stream interface, accepts one operand pair per cycle and supports back-pressure.

Parameters:
WIDTH, 4, operand width in bits; power of two, 4..32; product is 2*WIDTH bits.
LEVELS, log2(WIDTH), derived localparam; number of recursion levels; not user-overridable.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
out_product  output  2*WIDTH  a*b
busy  output  1  any pipeline stage holds a valid token

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - All stage valid bits, all data registers, out_valid, out_product and busy go to 0 immediately on rst.
  - in_ready is 1 after reset is released.
- Pipeline stages (total latency L = LEVELS+1 register stages):
  - S0 registers the operands.
  - S1 registers all (WIDTH/2)^2 2x2 base products, each 4 bits wide.
  - Sk (k = 2..L-1) combines four (2^(k-1))-bit sub-products into one 2^k-bit product: P = HH<<w + (HL+LH)<<(w/2) + LL. The middle sum is carried at full width with no truncation.
  - The last stage drives out_product.
  - Example: WIDTH=4 gives latency 3; WIDTH=8 gives latency 4.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - A transfer occurs when in_valid & in_ready.
  - If not stalled, every stage advances by one each cycle and bubbles propagate as valid=0. Bubbles are not collapsed.
  - If stalled, all stages hold. out_product and out_valid stay stable until accepted.
  - in_valid while stalled is ignored, so the upstream source must hold its data.
  - Throughput is 1 product per cycle when out_ready stays high.
- Simultaneous events: an output acceptance and a new input in the same cycle are both honoured, and the pipeline shifts.
- out_product is a don't-care when out_valid=0, but must equal its last value while a stall is in effect.
- busy = OR of all stage valid bits.
- Arithmetic: unsigned by default. out_product is exactly a*b in 2*WIDTH bits, and overflow is impossible. Corner values: 0*x = 0; (2^W-1)^2 = 2^(2W) - 2^(W+1) + 1.
- Reset mid-operation: all in-flight tokens are discarded. No out_valid pulse appears for them after reset is released.

Optional Feature:
- Macro: VEDIC_SIGNED_EN.
- When defined, add port `in_signed` (input, 1 bit), sampled with the operands and carried down the pipe.
- If in_signed=1:
  - S0 stores |a|, |b| (two's complement) plus sign = a[W-1]^b[W-1].
  - The final stage negates the unsigned product when sign=1.
  - The result is a two's-complement 2*WIDTH-bit product. -2^(W-1) is handled: its magnitude fits in W unsigned bits.
- If in_signed=0, the transaction behaves as unsigned.
- Latency is unchanged.
- Without the macro, the port does not exist and all operations are unsigned.

Test Plan:
1. WIDTH=4, out_ready=1, single transfers of 15*11, 15*15, 14*14, 13*12 -> out_product 0xA5, 0xE1, 0xC4, 0x9C, each exactly 3 cycles after its accept edge.
2. WIDTH=4, back-to-back 4 pairs on consecutive cycles -> 4 consecutive out_valid cycles, results in order, in_ready stays 1.
3. Back-pressure: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, out_product unchanged, no token lost or duplicated. After release, the remaining results drain in order.
4. WIDTH=8 corners: 255*255 -> 0xFE01; 0*200 -> 0x0000; 128*2 -> 0x0100; latency 4.
5. rst asserted with 2 tokens in flight -> out_valid, busy and out_product go to 0 immediately. No stale out_valid appears after release, and the next accepted 3*5 gives 0x0F.
6. VEDIC_SIGNED_EN, WIDTH=4, in_signed=1:
   - -8*7 -> 0xC8
   - -8*-8 -> 0x40
   - -1*-1 -> 0x01
   - with in_signed=0, 0x8*0x7 -> 0x38.
